// File: rtl/rptr_empty_fwft_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rptr_empty_fwft_if                                                       |
// | Read-side FIFO bundle: comparator/RAM inputs and FWFT consumer outputs.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface rptr_empty_fwft_if #(
   parameter int ADDRSIZE = 4,
   parameter int DSIZE    = 8
);
   logic                aempty_n;
   logic [DSIZE-1:0]    mem_rdata;
   logic                rd_en;
   logic [ADDRSIZE-1:0] raddr;
   logic [ADDRSIZE-1:0] rptr;
   logic                rempty;
   logic [DSIZE-1:0]    dout;
   logic                dout_valid;
   logic                underflow;

   modport master (
      input  aempty_n, mem_rdata, rd_en,
      output raddr, rptr, rempty, dout, dout_valid, underflow
   );

   modport slave (
      output aempty_n, mem_rdata, rd_en,
      input  raddr, rptr, rempty, dout, dout_valid, underflow
   );
endinterface
`default_nettype wire

// File: rtl/rptr_empty_fwft.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rptr_empty_fwft                                                          |
// | Async-FIFO read pointer, two-stage empty flag and FWFT output register.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rptr_empty_fwft #(
   parameter int ADDRSIZE = 4,
   parameter int DSIZE    = 8
) (
   input  logic                  rclk,
   input  logic                  rrst,
   rptr_empty_fwft_if.master     rif
);

   logic [ADDRSIZE-1:0] r_bin;
   logic [ADDRSIZE-1:0] r_gray;
   logic [ADDRSIZE-1:0] w_bnext;
   logic [ADDRSIZE-1:0] w_gnext;
   logic                r_rempty;
   logic                r_rempty2;
   logic [DSIZE-1:0]    r_dout;
   logic                r_valid;
   logic                r_underflow;
   logic                w_fetch;
   logic                w_aempty_n;

   assign w_aempty_n = rif.aempty_n;

   // Empty sets with no clock the moment the comparator drops aempty_n,
   // and releases only after two rclk edges of aempty_n being high.
   always_ff @(posedge rclk or posedge rrst or negedge w_aempty_n) begin
      if (rrst) begin
         {r_rempty, r_rempty2} <= 2'b11;
      end else if (!w_aempty_n) begin
         {r_rempty, r_rempty2} <= 2'b11;
      end else begin
         {r_rempty, r_rempty2} <= {r_rempty2, ~w_aempty_n};
      end
   end

   assign w_fetch = !r_rempty && (!r_valid || rif.rd_en);
   assign w_bnext = r_bin + {{(ADDRSIZE-1){1'b0}}, w_fetch};
   assign w_gnext = (w_bnext >> 1) ^ w_bnext;

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         r_bin       <= '0;
         r_gray      <= '0;
         r_dout      <= '0;
         r_valid     <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_bin       <= w_bnext;
         r_gray      <= w_gnext;
         r_underflow <= rif.rd_en && !r_valid;
         if (w_fetch) begin
            r_dout  <= rif.mem_rdata;
            r_valid <= 1'b1;
         end else if (rif.rd_en && r_valid) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rif.raddr      = r_bin;
   assign rif.rptr       = r_gray;
   assign rif.rempty     = r_rempty;
   assign rif.dout       = r_dout;
   assign rif.dout_valid = r_valid;
   assign rif.underflow  = r_underflow;

endmodule
`default_nettype wire

// File: doc/rptr_empty_fwft.md
# rptr_empty_fwft

Read-side pointer and empty controller for the style-2 asynchronous FIFO, the counterpart of the write-pointer/full block in the write domain. It owns the read binary and Gray pointers and a two-stage empty flag that asserts asynchronously from the async comparator's `aempty_n` and deasserts synchronously. It also adds a first-word-fall-through (FWFT) output register in front of the dual-port RAM's asynchronous read port, so consumers see data with a valid/pop handshake.

## Interface
- `ADDRSIZE`, default 4: pointer width; RAM depth is 2^ADDRSIZE.
- `DSIZE`, default 8: data word width.

- `rclk` in 1: read-domain clock; all state is on its rising edge.
- `rrst` in 1: reset, asynchronous, active-high.
- `aempty_n` in 1: almost-empty from the async pointer comparator, active-low, asynchronous to `rclk`.
- `mem_rdata` in DSIZE: RAM read data; combinational function of `raddr`.
- `rd_en` in 1: consumer pop; acknowledges the current `dout`.
- `raddr` out ADDRSIZE: binary read address to the RAM (= `rbin`).
- `rptr` out ADDRSIZE: registered Gray read pointer to the async comparator.
- `rempty` out 1: RAM-side empty flag.
- `dout` out DSIZE: FWFT output word.
- `dout_valid` out 1: `dout` holds an unconsumed word.
- `underflow` out 1: one-cycle pulse when `rd_en` is high while `dout_valid` is low.

## Operation
- Reset values (`rrst` high, immediate): `rbin`=0, `rptr`=0, `{rempty,rempty2}`=2'b11, `dout`=0, `dout_valid`=0, `underflow`=0.
- Empty flag priority:
  - `rrst` high → 2'b11.
  - else `aempty_n` low → 2'b11, set asynchronously.
  - else on each `rclk` edge, `{rempty,rempty2} <= {rempty2, ~aempty_n}`.
- `fetch = !rempty && (!dout_valid || rd_en)`.
  - It is evaluated from values registered before the edge; an asynchronously set `rempty` blocks the fetch.
- On `fetch`:
  - `dout <= mem_rdata` (the word at the current `raddr`).
  - `dout_valid <= 1`.
  - `rbnext = rbin + 1`.
- Otherwise:
  - `rbnext = rbin`.
  - If `rd_en && dout_valid`, then `dout_valid <= 0` and `dout` holds its value.
- Pointer update:
  - `rgnext = (rbnext >> 1) ^ rbnext`.
  - `rbin <= rbnext`; `rptr <= rgnext`.
- Arithmetic is modulo 2^ADDRSIZE. Wrap 15→0 (Gray 4'b1000→4'b0000) needs no special handling.
- `underflow <= rd_en && !dout_valid` each cycle. The pop is ignored and no pointer moves.
- Output buffer states:
  - EMPTY (`dout_valid`=0) → VALID on `fetch`.
  - VALID → VALID on `fetch` (pop and refill in the same cycle, or refill-only is impossible since `fetch` requires a pop while valid).
  - VALID → EMPTY on `rd_en && !fetch`.
- `dout` changes only on a `fetch` edge or on reset.

## Timing
- Empty release: `aempty_n` rising before edge N gives `rempty`=0 after edge N+1 (two edges).
  - The first `fetch` happens at edge N+2; `dout_valid`=1 and `rptr` advances after edge N+2.
- Empty assertion: `rempty` rises within the same cycle `aempty_n` falls, with no clock required.
- Throughput: with `rd_en` held high and `rempty` low, one word per `rclk`, with no bubbles.
- Pop latency: `rd_en` sampled at edge K consumes the current `dout`. The replacement, if any, is visible after edge K.
- `rptr` is a direct flop output with exactly one bit toggling per increment, and is safe for the async comparator.
- Reset mid-transfer: all outputs return to their reset values without a clock. After `rrst` falls, the block behaves as after power-up.

## Test plan
- **Reset:** assert `rrst` mid-stream with `dout_valid`=1 and `rbin`=5 → immediately `rempty`=1, `dout_valid`=0, `dout`=0, `raddr`=0, `rptr`=0.
- **First word fall-through:** RAM holds 0xA5 at address 0; raise `aempty_n` before edge 1 with `rd_en`=0 → `rempty`=0 after edge 2; `dout`=0xA5, `dout_valid`=1, `raddr`=1, `rptr`=4'b0001 after edge 3; all stay stable with `rd_en` low.
- **Streaming:** RAM[i]=i, `aempty_n` high, `rd_en` held high for 20 cycles → `dout` steps 0,1,2,… one per cycle. `raddr` wraps 15→0 and `rptr` goes 4'b1000→4'b0000. Exactly one `rptr` bit toggles per cycle.
- **Asynchronous empty:** drop `aempty_n` mid-cycle while streaming → `rempty`=1 before the next edge; no further `fetch` happens. The buffered `dout` stays valid until popped, then `dout_valid`=0.
- **Underflow:** after reset, pulse `rd_en` for 1 cycle with `dout_valid`=0 → `underflow`=1 for exactly one cycle; `raddr` and `rptr` remain 0.
- **Pop/refill collision:** `dout_valid`=1, `rempty`=0, `rd_en`=1 → `dout_valid` stays 1 and `dout` updates to the next word in the same edge. Repeat with `rempty`=1 → `dout_valid`=0.
